miner_job_scheduler: RTL and testbench

Job sequencer between the UART command block and the SHA-256 hashing core. It double-buffers incoming jobs (midstate, work data, nonce range) and launches each one on the core with a one-cycle start pulse. It tracks nonce progress to detect when a range is exhausted, drains the core pipeline, then launches the next job. Golden nonces reported by the core are queued in a small FIFO for the comm block to read.

---
 rtl/miner_job_scheduler_pkg.sv | 22 ++
 rtl/miner_job_scheduler_ticket_fifo.sv | 58 +++++
 rtl/miner_job_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_miner_job_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_job_scheduler_pkg.sv
// Shared types and widths for the miner job scheduler.
package miner_sched_pkg;

    localparam int MIDSTATE_W = 256;
    localparam int DATA_W     = 96;
    localparam int NONCE_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DRAIN
    } sched_state_t;

    typedef struct packed {
        logic [MIDSTATE_W-1:0] midstate;
        logic [DATA_W-1:0]     data;
        logic [NONCE_W-1:0]    nonce_min;
        logic [NONCE_W-1:0]    nonce_max;
    } job_t;

endpackage

// File: rtl/miner_job_scheduler_ticket_fifo.sv
// Small synchronous FIFO for golden-nonce tickets. The head is read from
// registered storage and forced to zero while empty.
module ticket_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees a slot, so a push is accepted even when full.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage, pointers and fill count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/miner_job_scheduler.sv
// Job sequencer between the command block and the SHA-256 core: one pending
// job slot, a START/RUN/DRAIN sequence per job, and a golden-nonce FIFO.
// Optional feature macro: JOB_SCHED_ABORT_ON_TICKET_EN (a ticket seen in RUN
// ends the search and moves straight to DRAIN).
module miner_job_scheduler
    import miner_sched_pkg::*;
#(
    parameter int LOOP_LOG2    = 5,
    parameter int DRAIN_CYCLES = 136,
    parameter int TICKET_DEPTH = 4
) (
    input  logic                  hash_clk,
    input  logic                  reset,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [MIDSTATE_W-1:0] job_midstate,
    input  logic [DATA_W-1:0]     job_data,
    input  logic [NONCE_W-1:0]    job_nonce_min,
    input  logic [NONCE_W-1:0]    job_nonce_max,
    output logic [MIDSTATE_W-1:0] core_midstate,
    output logic [DATA_W-1:0]     core_data,
    output logic [NONCE_W-1:0]    core_nonce_min,
    output logic [NONCE_W-1:0]    core_nonce_max,
    output logic                  core_start,
    input  logic                  core_golden,
    input  logic [NONCE_W-1:0]    core_golden_nonce,
    output logic                  ticket_valid,
    output logic [NONCE_W-1:0]    ticket_nonce,
    input  logic                  ticket_ready,
    output logic                  busy,
    output logic                  job_done,
    output logic                  ticket_drop
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    sched_state_t          state;
    sched_state_t          next_state;
    job_t                  pend;
    job_t                  core_job;
    logic                  pend_valid;
    logic [NONCE_W-1:0]    nonce_cur;
    logic [LOOP_LOG2-1:0]  step_cnt;
    logic [DW-1:0]         drain_cnt;

    logic                  accept;
    logic                  range_ok;
    logic                  step_wrap;
    logic                  last_nonce;
    logic                  drain_last;
    logic                  golden_live;
    logic                  ticket_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  abort_hit;

    assign job_ready   = !pend_valid;
    assign accept      = job_valid && !pend_valid;
    assign range_ok    = (core_job.nonce_min <= core_job.nonce_max);
    assign step_wrap   = (step_cnt == '1);
    assign last_nonce  = (nonce_cur == core_job.nonce_max);
    assign drain_last  = (drain_cnt == DW'(1));
    assign golden_live = core_golden && ((state == ST_RUN) || (state == ST_DRAIN));
    assign ticket_valid = !fifo_empty;
    assign ticket_pop  = ticket_valid && ticket_ready;

`ifdef JOB_SCHED_ABORT_ON_TICKET_EN
    assign abort_hit = core_golden && (state == ST_RUN);
`else
    assign abort_hit = 1'b0;
`endif

    assign core_midstate  = core_job.midstate;
    assign core_data      = core_job.data;
    assign core_nonce_min = core_job.nonce_min;
    assign core_nonce_max = core_job.nonce_max;

    // State register.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (pend_valid) next_state = ST_START;
            end
            ST_START: begin
                next_state = range_ok ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (abort_hit || (step_wrap && last_nonce)) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_last) next_state = pend_valid ? ST_START : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output decode from state.
    always_comb begin
        core_start = (state == ST_START);
        busy       = (state != ST_IDLE);
        job_done   = ((state == ST_START) && !range_ok) ||
                     ((state == ST_DRAIN) && drain_last);
    end

    // Pending slot and core job registers; the core copy is taken on the edge
    // into START so core_* already hold the new job while core_start is high.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            pend       <= '0;
            pend_valid <= 1'b0;
            core_job   <= '0;
        end else begin
            if (next_state == ST_START) begin
                core_job   <= pend;
                pend_valid <= 1'b0;
            end else if (accept) begin
                pend_valid <= 1'b1;
                pend       <= '{midstate:  job_midstate,
                                data:      job_data,
                                nonce_min: job_nonce_min,
                                nonce_max: job_nonce_max};
            end
        end
    end

    // Nonce progress and drain countdown.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            nonce_cur <= '0;
            step_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            if (next_state == ST_START) begin
                nonce_cur <= pend.nonce_min;
                step_cnt  <= '0;
            end else if (state == ST_RUN) begin
                step_cnt <= step_cnt + LOOP_LOG2'(1);
                // Compare before increment so a max of all-ones never wraps.
                if (step_wrap && !last_nonce) begin
                    nonce_cur <= nonce_cur + 32'd1;
                end
            end
            if ((state != ST_DRAIN) && (next_state == ST_DRAIN)) begin
                drain_cnt <= DW'(DRAIN_CYCLES);
            end else if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt - DW'(1);
            end
        end
    end

    // Sticky drop flag for tickets lost to a full FIFO.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            ticket_drop <= 1'b0;
        end else if (golden_live && fifo_full && !ticket_pop) begin
            ticket_drop <= 1'b1;
        end
    end

    ticket_fifo #(
        .DEPTH (TICKET_DEPTH),
        .WIDTH (NONCE_W)
    ) u_ticket_fifo (
        .clk   (hash_clk),
        .rst   (reset),
        .push  (golden_live),
        .pop   (ticket_ready),
        .din   (core_golden_nonce),
        .dout  (ticket_nonce),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_miner_job_scheduler.sv
// Bench for miner_job_scheduler (LOOP_LOG2=2, DRAIN_CYCLES=8). A timeline
// model computes each job's phase from its elapsed cycle count and keeps the
// ticket FIFO as a queue; directed sequences pin the model with literals.
module tb_miner_job_scheduler;

    localparam int STEP  = 4;
    localparam int DRAIN = 8;
    localparam int DEPTH = 4;

    logic         hash_clk = 1'b0;
    logic         reset = 1'b1;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [255:0] job_midstate = '0;
    logic [95:0]  job_data = '0;
    logic [31:0]  job_nonce_min = '0;
    logic [31:0]  job_nonce_max = '0;
    logic [255:0] core_midstate;
    logic [95:0]  core_data;
    logic [31:0]  core_nonce_min;
    logic [31:0]  core_nonce_max;
    logic         core_start;
    logic         core_golden = 1'b0;
    logic [31:0]  core_golden_nonce = '0;
    logic         ticket_valid;
    logic [31:0]  ticket_nonce;
    logic         ticket_ready = 1'b0;
    logic         busy;
    logic         job_done;
    logic         ticket_drop;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model state
    bit           m_pend_v;
    logic [255:0] m_pend_mid, m_cur_mid;
    logic [95:0]  m_pend_data, m_cur_data;
    logic [31:0]  m_pend_min, m_pend_max, m_cur_min, m_cur_max;
    bit           m_active, m_invalid, m_drop;
    longint       m_e, m_run_len;
    logic [31:0]  m_q[$];

    miner_job_scheduler #(
        .LOOP_LOG2    (2),
        .DRAIN_CYCLES (8),
        .TICKET_DEPTH (4)
    ) dut (
        .hash_clk          (hash_clk),
        .reset             (reset),
        .job_valid         (job_valid),
        .job_ready         (job_ready),
        .job_midstate      (job_midstate),
        .job_data          (job_data),
        .job_nonce_min     (job_nonce_min),
        .job_nonce_max     (job_nonce_max),
        .core_midstate     (core_midstate),
        .core_data         (core_data),
        .core_nonce_min    (core_nonce_min),
        .core_nonce_max    (core_nonce_max),
        .core_start        (core_start),
        .core_golden       (core_golden),
        .core_golden_nonce (core_golden_nonce),
        .ticket_valid      (ticket_valid),
        .ticket_nonce      (ticket_nonce),
        .ticket_ready      (ticket_ready),
        .busy              (busy),
        .job_done          (job_done),
        .ticket_drop       (ticket_drop)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pend_v = 0; m_active = 0; m_invalid = 0; m_drop = 0;
        m_e = 0; m_run_len = 0;
        m_pend_mid = '0; m_pend_data = '0; m_pend_min = '0; m_pend_max = '0;
        m_cur_mid = '0; m_cur_data = '0; m_cur_min = '0; m_cur_max = '0;
        m_q.delete();
    endtask

    function automatic bit m_done();
        return m_active && ((m_invalid && m_e == 0) ||
                            (!m_invalid && m_e == m_run_len + DRAIN));
    endfunction

    function automatic bit m_live();
        return m_active && !m_invalid && m_e >= 1 && m_e <= m_run_len + DRAIN;
    endfunction

    // advance the model by one clock edge using the inputs present at the edge
    task automatic model_step();
        bit acc, pop, push, done;
        if (reset) return;
        acc  = job_valid && !m_pend_v;
        pop  = (m_q.size() > 0) && ticket_ready;
        push = core_golden && m_live();
        done = m_done();
        if (push && m_q.size() == DEPTH && !pop) begin
            m_drop = 1;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(core_golden_nonce);
        end
        if (m_active && !done) begin
`ifdef JOB_SCHED_ABORT_ON_TICKET_EN
            if (core_golden && m_e >= 1 && m_e <= m_run_len) m_run_len = m_e;
`endif
            m_e++;
        end else if (m_pend_v) begin
            m_cur_mid = m_pend_mid; m_cur_data = m_pend_data;
            m_cur_min = m_pend_min; m_cur_max = m_pend_max;
            m_active = 1; m_e = 0; m_pend_v = 0;
            m_invalid = (m_cur_min > m_cur_max);
            m_run_len = m_invalid ? 0 :
                (longint'({32'd0, m_cur_max}) - longint'({32'd0, m_cur_min}) + 1) * STEP;
        end else begin
            m_active = 0;
        end
        if (acc) begin
            m_pend_v = 1;
            m_pend_mid = job_midstate; m_pend_data = job_data;
            m_pend_min = job_nonce_min; m_pend_max = job_nonce_max;
        end
    endtask

    task automatic compare_outputs();
        chk("busy", busy, m_active);
        chk("core_start", core_start, m_active && m_e == 0);
        chk("job_done", job_done, m_done());
        chk("job_ready", job_ready, !m_pend_v);
        chk("ticket_valid", ticket_valid, m_q.size() > 0);
        if (m_q.size() > 0) chk("ticket_nonce", ticket_nonce, m_q[0]);
        chk("ticket_drop", ticket_drop, m_drop);
        chk("core_midstate", core_midstate, m_cur_mid);
        chk("core_data", core_data, m_cur_data);
        chk("core_nonce_min", core_nonce_min, m_cur_min);
        chk("core_nonce_max", core_nonce_max, m_cur_max);
    endtask

    // one clock: compare at the falling edge, step the model at the rising edge
    task automatic tick();
        @(negedge hash_clk);
        compare_outputs();
        @(posedge hash_clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_job(input logic [31:0] mn, input logic [31:0] mx);
        for (int i = 0; i < 8; i++) job_midstate[i*32 +: 32] = $urandom();
        for (int i = 0; i < 3; i++) job_data[i*32 +: 32] = $urandom();
        job_nonce_min = mn;
        job_nonce_max = mx;
    endtask

    task automatic offer(input logic [31:0] mn, input logic [31:0] mx);
        set_job(mn, mx);
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
    endtask

    task automatic wait_done(output int t);
        int n;
        n = 0;
        while (job_done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        if (job_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_done: got timeout expected job_done within 400 cycles");
        end
        t = cyc;
    endtask

    initial begin
        int t0, td, td2;
        logic [31:0] exp_q [4];
        model_reset();
        do_reset();

        // reset values
        chk("rst_job_ready", job_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_job_done", job_done, 1'b0);
        chk("rst_ticket_valid", ticket_valid, 1'b0);
        chk("rst_ticket_nonce", ticket_nonce, 32'h0);
        chk("rst_ticket_drop", ticket_drop, 1'b0);
        chk("rst_core_nonce_max", core_nonce_max, 32'h0);

        // single job 0x10..0x13: START at T, done at T+24, idle at T+25
        offer(32'h10, 32'h13);
        chk("accept_job_ready", job_ready, 1'b0);
        tick();
        chk("lat_core_start", core_start, 1'b1);
        chk("lat_core_nonce_min", core_nonce_min, 32'h10);
        t0 = cyc;
        tick();
        chk("run_busy", busy, 1'b1);
        wait_done(td);
        chk("job1_done_offset", td - t0, 24);
        tick();
        chk("job1_busy_fall", busy, 1'b0);

        // second job offered during RUN starts right after the first job_done
        offer(32'h10, 32'h13);
        tick();
        t0 = cyc;
        tick(); tick(); tick();
        offer(32'h20, 32'h20);
        chk("b2b_job_ready", job_ready, 1'b0);
        wait_done(td);
        chk("b2b_done_offset", td - t0, 24);
        tick();
        chk("b2b_core_start", core_start, 1'b1);
        chk("b2b_core_nonce_min", core_nonce_min, 32'h20);
        wait_done(td2);
        chk("job2_done_offset", td2 - td - 1, 12);
        tick();

        // top-of-range job: exactly 4 RUN cycles; inverted range: done in START
        offer(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        t0 = cyc;
        wait_done(td);
        chk("max_done_offset", td - t0, 12);
        tick();
        offer(32'h5, 32'h4);
        tick();
        chk("inv_core_start", core_start, 1'b1);
        chk("inv_job_done", job_done, 1'b1);
        tick();
        chk("inv_busy", busy, 1'b0);

        // ticket FIFO: fill, push+pop at full, drop, drain in order
        offer(32'h0, 32'h3);
        core_golden = 1'b1; core_golden_nonce = 32'hDEAD;
        tick();                                      // edge into START: ignored
        chk("start_no_ticket", ticket_valid, 1'b0);
        tick();                                      // edge in START: ignored
        chk("start_no_ticket2", ticket_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            core_golden_nonce = 32'hA0 + 32'(i);
            tick();
        end
        core_golden = 1'b0;
        chk("full_head", ticket_nonce, 32'hA0);
        chk("full_no_drop", ticket_drop, 1'b0);
        core_golden = 1'b1; core_golden_nonce = 32'hA4; ticket_ready = 1'b1;
        tick();
        chk("pushpop_no_drop", ticket_drop, 1'b0);
        chk("pushpop_head", ticket_nonce, 32'hA1);
        core_golden_nonce = 32'hA5; ticket_ready = 1'b0;
        tick();
        core_golden = 1'b0;
        chk("drop_set", ticket_drop, 1'b1);
        chk("drop_head", ticket_nonce, 32'hA1);
        exp_q[0] = 32'hA1; exp_q[1] = 32'hA2; exp_q[2] = 32'hA3; exp_q[3] = 32'hA4;
        ticket_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pop_order", ticket_nonce, exp_q[i]);
            tick();
        end
        chk("drained_empty", ticket_valid, 1'b0);
        ticket_ready = 1'b0;
        wait_done(td);
        tick();
        core_golden = 1'b1; core_golden_nonce = 32'hBEEF;
        tick();
        core_golden = 1'b0;
        chk("idle_no_push", ticket_valid, 1'b0);
        chk("drop_sticky", ticket_drop, 1'b1);

        // reset mid-RUN with a pending job: nothing reported afterwards
        do_reset();
        offer(32'h0, 32'h7);
        tick(); tick(); tick();
        offer(32'h40, 32'h41);
        chk("mid_pending", job_ready, 1'b0);
        tick();
        do_reset();
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_job_ready", job_ready, 1'b1);
        chk("mid_rst_core_min", core_nonce_min, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_rst_no_done", job_done, 1'b0);
            chk("mid_rst_no_start", core_start, 1'b0);
        end

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [31:0] mn, mx;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                mn = $urandom_range(10, 1000);
                mx = mn - $urandom_range(1, 5);
            end else if (r == 1) begin
                mn = 32'hFFFF_FFFF - $urandom_range(0, 2);
                mx = 32'hFFFF_FFFF;
            end else begin
                mn = $urandom_range(0, 32'hFFFF_0000);
                mx = mn + $urandom_range(0, 3);
            end
            set_job(mn, mx);
            job_valid = ($urandom_range(0, 3) == 0);
            core_golden = ($urandom_range(0, 4) == 0);
            core_golden_nonce = $urandom();
            ticket_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            else tick();
        end
        job_valid = 1'b0;
        core_golden = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
